// File: rtl/gf2m_seq_reducer.sv
// ---------------------------------------------------------------------------
// gf2m_seq_reducer
//
// Iterative reducer for GF(2^M) polynomial-basis arithmetic. It takes a
// (2M-1)-bit carry-less product and returns its remainder modulo
//   f(x) = x^M + x^K1 + x^K2 + x^K3 + 1   (POLY_TYPE = 1, pentanomial)
//   f(x) = x^M + x^K1 + 1                 (POLY_TYPE = 0, trinomial)
// On each RUN clock it folds up to FOLD_BITS of the high-order bits back into
// the low part. ITER = ceil((M-1)/FOLD_BITS) folds are needed per operand.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds valid and data stable
// until that edge; ready may be driven independently of valid.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   block can accept in_data (high in IDLE only)
//   in_data    unreduced product, 2M-1 bits
//   out_valid  out_data is valid (high in DONE only)
//   out_ready  consumer accepts out_data
//   out_data   reduced result, degree < M, registered
//   busy       high while folding (RUN)
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module gf2m_seq_reducer #(
  parameter int M         = 163,
  parameter int POLY_TYPE = 1,
  parameter int K1        = 7,
  parameter int K2        = 6,
  parameter int K3        = 3,
  parameter int FOLD_BITS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-2:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_data,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  localparam int W    = 2 * M - 1;
  localparam int ITER = (M - 1 + FOLD_BITS - 1) / FOLD_BITS;
  localparam int CW   = $clog2(ITER + 1);

  // Reject configurations whose fold targets could land inside the chunk
  // being folded, or whose polynomial exponents are out of order.
  generate
    if (FOLD_BITS < 1 || FOLD_BITS > M - K1) begin : g_bad_fold
      $error("gf2m_seq_reducer: FOLD_BITS must lie in 1..M-K1");
    end
    if (POLY_TYPE == 1 && !(K1 > K2 && K2 > K3 && K3 > 0)) begin : g_bad_penta
      $error("gf2m_seq_reducer: pentanomial needs K1 > K2 > K3 > 0");
    end
    if (K1 <= 0 || K1 >= M) begin : g_bad_k1
      $error("gf2m_seq_reducer: K1 must lie in 1..M-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [W-1:0]  r;
  logic [W-1:0]  fold;
  logic          last_iter;

  assign last_iter = (cnt == CW'(ITER - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // One fold step. Iteration cnt owns chunk r[hi:lo]; everything above hi is
  // already zero. Each set chunk bit x^i (i >= M) is replaced by
  // x^(i-M) * (f(x) - x^M). All targets sit below lo, so chunk bits never
  // disturb each other and the chunk can be cleared in place.
  // -------------------------------------------------------------------------
  always_comb begin
    int hi;
    int lo;
    fold = r;
    hi   = (2 * M - 2) - int'(cnt) * FOLD_BITS;
    lo   = hi - FOLD_BITS + 1;
    if (lo < M) lo = M;
    for (int i = M; i <= 2 * M - 2; i++) begin
      if (i >= lo && i <= hi) begin
        fold[i]          = 1'b0;
        fold[i - M]      = fold[i - M] ^ r[i];
        fold[i - M + K1] = fold[i - M + K1] ^ r[i];
        if (POLY_TYPE == 1) begin
          fold[i - M + K2] = fold[i - M + K2] ^ r[i];
          fold[i - M + K3] = fold[i - M + K3] ^ r[i];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers. out_data only moves on the final fold so it stays
  // stable through DONE and after returning to IDLE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r        <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r   <= in_data;
            cnt <= '0;
          end
        end
        RUN: begin
          r   <= fold;
          cnt <= cnt + CW'(1);
          if (last_iter) out_data <= fold[M-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gf2m_seq_reducer.md
Name: gf2m_seq_reducer

Overview:
Iterative modular reducer for GF(2^M) polynomial-basis arithmetic. It reduces a (2M-1)-bit carry-less product modulo f(x) = x^M + x^K1 + x^K2 + x^K3 + 1 (pentanomial) or f(x) = x^M + x^K1 + 1 (trinomial). It folds FOLD_BITS high-order bits per clock, so area and latency trade off through one parameter. It sits between the Karatsuba multiplier output and the field-arithmetic datapath, and uses a valid/ready handshake on both sides.

Parameters:
M, 163, field degree; input width 2M-1, output width M.
POLY_TYPE, 1, 1 = pentanomial (K1,K2,K3 used); 0 = trinomial (K1 only; K2, K3 ignored).
K1, 7, highest middle exponent; K1 > K2 > K3 > 0 when POLY_TYPE=1.
K2, 6, second middle exponent.
K3, 3, third middle exponent.
FOLD_BITS, 32, bits folded per cycle; legal range 1..M-K1. Elaboration error if out of range.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data valid
in_ready  out  1  block can accept in_data
in_data  in  2M-1  unreduced product
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
out_data  out  M  reduced result, degree < M
busy  out  1  high in RUN

Behaviour:
- ITER = ceil((M-1)/FOLD_BITS) is a localparam. For the defaults ITER = 6.
- Internal state: 2M-1-bit working register r, iteration counter cnt (clog2(ITER+1) bits), FSM {IDLE, RUN, DONE}.
- Reset (rst_n low, asynchronous): FSM=IDLE, r=0, cnt=0, out_valid=0, busy=0, in_ready=1, out_data=0. Reset asserted mid-RUN or mid-DONE aborts the operation and discards it. No output is produced for it.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==RUN).
- IDLE: on in_valid&&in_ready, r<=in_data, cnt<=0, go to RUN.
- RUN, iteration j (0-based):
  - Chunk top hi = 2M-2 - j*FOLD_BITS.
  - Chunk low lo = max(hi-FOLD_BITS+1, M).
  - Chunk c = r[hi:lo].
  - Clear r[hi:lo]. XOR c into r at offsets lo-M, lo-M+K1, and (pentanomial only) lo-M+K2 and lo-M+K3.
  - All fold targets lie strictly below lo, guaranteed by FOLD_BITS <= M-K1.
  - cnt<=cnt+1. After iteration ITER-1 (final chunk, lo=M, possibly partial width) go to DONE.
- DONE: out_data = r[M-1:0], held stable while out_valid && !out_ready. On out_valid&&out_ready go to IDLE.
- Latency: input accepted at edge t means out_valid is high after edge t+ITER.
- Throughput: one result per ITER+2 cycles. No overlap; in_ready is low in RUN and DONE.
- in_valid while in_ready is low is ignored and has no side effect.
- out_data is registered and never changes except when entering DONE or on reset.
- Result must be bit-identical to the golden model: polynomial remainder of in_data mod f(x).

Test Plan:
- Defaults, in_data = 1<<163 -> after 6 cycles out_data = 0xC9 (x^7+x^6+x^3+1).
- Defaults, in_data = 1<<170 -> out_data = 0x6480. in_data = 1<<162 -> out_data = 1<<162 (passthrough). in_data = 0 -> 0.
- Defaults, 10,000 random 325-bit inputs plus all-ones input -> out_data matches the golden bit-serial mod-f model on every transaction.
- Backpressure: hold out_ready=0 for 20 cycles in DONE; pulse in_valid meanwhile -> out_data stable, in_ready=0, second input not captured. Release -> one handshake, then IDLE.
- Reset mid-RUN at iteration 3 -> out_valid, busy and out_data go to 0 immediately. The next transaction after reset reduces correctly.
- Parameter sweep (golden model check, latency = ITER):
  - M=163, FOLD_BITS=1 -> ITER=162.
  - M=163, FOLD_BITS=156 -> ITER=2.
  - M=233, POLY_TYPE=0, K1=74, FOLD_BITS=64 -> ITER=4.
